ls_wb_stage: RTL and testbench
==============================

# ls_wb_stage

LSU output pipeline stage and producer of the LS→WB interface consumed by the write-back unit. It accepts one retired memory-stage beat per handshake and aligns/sign-extends raw load data. It holds the result in the LS_WB_reg_* register set until write-back takes it, and drops all in-flight state on a write-back flush.

## Interface
- XLEN, 64, data/PC width; only 64 supported.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WB_LS_ls_ready  in  1  write-back accepts the current LS_WB beat.
- WB_LS_flush_flag  in  1  write-back redirect/satp change/sflush; kill everything held.
- MEM_LS_valid  in  1  memory stage presents a beat.
- LS_MEM_ready  out  1  this stage accepts the beat (handshake = valid & ready).
- MEM_LS_PC, MEM_LS_next_PC  in  64 each  instruction PC / successor PC.
- MEM_LS_inst  in  32  instruction word.
- MEM_LS_ctrl  in  6  {sflush, trap, mret, sret, dret, csr_wen}, bit 5 = sflush.
- MEM_LS_csr_ren  in  1  CSR read; write-back substitutes CSR data.
- MEM_LS_csr_addr  in  12  CSR address.
- MEM_LS_trap_cause, MEM_LS_trap_tval  in  64 each  trap cause / tval.
- MEM_LS_rd  in  5, MEM_LS_dest_wen  in  1  GPR destination.
- MEM_LS_load  in  1  beat is a load; data needs alignment.
- MEM_LS_load_size  in  2  0 byte, 1 half, 2 word, 3 double.
- MEM_LS_load_unsigned  in  1  zero-extend instead of sign-extend.
- MEM_LS_load_offset  in  3  address bits [2:0].
- MEM_LS_data  in  64  raw bus doubleword (load) or result (non-load).
- LS_WB_reg_ls_valid  out  1  beat valid toward write-back.
- LS_WB_reg_PC, _next_PC, _inst, _sflush_valid, _trap_valid, _mret_valid, _sret_valid, _dret_valid, _trap_cause, _trap_tval, _csr_wen, _csr_ren, _csr_addr, _rd, _dest_wen, _data  out  widths as inputs  registered beat fields.

## Operation
- Load data: shifted = MEM_LS_data >> (offset*8); take low 8/16/32/64 bits per size; sign-extend from the top extracted bit unless unsigned. Size 3 ignores unsigned. Non-loads pass data unchanged.
- Alignment is combinational before the register; outputs never change while LS_WB_reg_ls_valid=1 and WB_LS_ls_ready=0.
- Register load enable = MEM_LS_valid & LS_MEM_ready & !WB_LS_flush_flag.
- Valid next state:
  - flush → 0;
  - else load → 1;
  - else WB_LS_ls_ready → 0;
  - else hold.
- Flush has priority over a simultaneous handshake. The incoming beat is consumed and discarded because upstream is flushed in the same cycle.
- Misaligned offsets are not checked here; trap beats carry data unmodified, and write-back ignores it.

## Timing
- Reset: LS_WB_reg_ls_valid=0, all LS_WB_reg_* fields 0, skid empty.
- Latency: handshake in cycle N → LS_WB_reg_ls_valid=1 in N+1.
- Full throughput: one beat per cycle while WB_LS_ls_ready=1.
- Without skid: LS_MEM_ready = !LS_WB_reg_ls_valid | WB_LS_ls_ready (combinational path from WB ready).
- Reset asserted mid-beat clears all state asynchronously; no beat is replayed.

## Configuration
- LS_WB_SKID_BUF_EN defined: adds a one-entry skid register.
  - LS_MEM_ready = !skid_valid, registered with no combinational path from WB_LS_ls_ready.
  - A beat arriving while output is full and stalled goes to skid.
  - Skid moves to output when WB takes the current beat.
  - Flush clears both entries.
- Undefined: single register, ready as in Timing. Throughput is identical in both modes.

## Structure
- Shared package/define header holds the MEM_LS_ctrl bit indices and load size encodings (LS_SIZE_B/H/W/D).
- Sub-module load_align (combinational shift/extract/extend), reusable by the AMO path.

## Test plan
- Load byte, data=64'h0000_0000_0000_8000, offset=1, signed → LS_WB_reg_data=64'hFFFF_FFFF_FFFF_FF80, valid one cycle later.
- Same with unsigned=1 → 64'h0000_0000_0000_0080; word offset=4, data=64'h8000_0001_xxxx_xxxx → 64'hFFFF_FFFF_8000_0001.
- WB_LS_ls_ready=0 for 3 cycles with MEM_LS_valid=1 → outputs stable; beat count out equals beats in (skid on: no loss, ready falls after 2nd beat).
- Flush asserted with handshake same cycle → LS_WB_reg_ls_valid=0 next cycle; next beat passes normally.
- Trap beat (cause 64'd13, tval 64'h8000_1003) → fields reproduced exactly, data unaltered.
- rst_n low mid-stall → all outputs 0 immediately, LS_MEM_ready=1 after release.

Source files
------------

// File: rtl/ls_wb_stage_pkg.sv
// Shared definitions for the LS->WB stage: control bit indices, load size
// encodings and the registered beat layout.
package ls_wb_stage_pkg;

   localparam int unsigned LS_XLEN = 64;

   // Bit positions within MEM_LS_ctrl
   localparam int unsigned CTRL_SFLUSH  = 5;
   localparam int unsigned CTRL_TRAP    = 4;
   localparam int unsigned CTRL_MRET    = 3;
   localparam int unsigned CTRL_SRET    = 2;
   localparam int unsigned CTRL_DRET    = 1;
   localparam int unsigned CTRL_CSR_WEN = 0;

   typedef enum logic [1:0] {
      LS_SIZE_B = 2'd0,
      LS_SIZE_H = 2'd1,
      LS_SIZE_W = 2'd2,
      LS_SIZE_D = 2'd3
   } ls_size_e;

   typedef struct packed {
      logic [LS_XLEN-1:0] pc;
      logic [LS_XLEN-1:0] next_pc;
      logic [31:0]        inst;
      logic               sflush_valid;
      logic               trap_valid;
      logic               mret_valid;
      logic               sret_valid;
      logic               dret_valid;
      logic [LS_XLEN-1:0] trap_cause;
      logic [LS_XLEN-1:0] trap_tval;
      logic               csr_wen;
      logic               csr_ren;
      logic [11:0]        csr_addr;
      logic [4:0]         rd;
      logic               dest_wen;
      logic [LS_XLEN-1:0] data;
   } ls_beat_t;

endpackage

// File: rtl/ls_wb_stage_load_align.sv
// Combinational load data alignment: shift by byte offset, extract the
// requested size, then sign- or zero-extend. Shared with the AMO path.
module load_align
   import ls_wb_stage_pkg::*;
#(
   parameter int unsigned XLEN = LS_XLEN
) (
   input  logic [XLEN-1:0] raw_data_i,
   input  ls_size_e        size_i,
   input  logic            unsigned_i,
   input  logic [2:0]      offset_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] shifted;
   logic            sext;

   always_comb begin
      shifted = raw_data_i >> {offset_i, 3'b000};
      sext    = !unsigned_i;
      data_o  = shifted;
      case (size_i)
         LS_SIZE_B: data_o = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
         LS_SIZE_H: data_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
         LS_SIZE_W: data_o = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
         default:   data_o = shifted;
      endcase
   end

endmodule

// File: rtl/ls_wb_stage.sv
// LSU output stage driving the LS_WB_reg_* interface toward write-back.
// Optional one-entry skid buffer selected by LS_WB_SKID_BUF_EN.
module ls_wb_stage
   import ls_wb_stage_pkg::*;
#(
   parameter int unsigned XLEN = LS_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            WB_LS_ls_ready,
   input  logic            WB_LS_flush_flag,
   input  logic            MEM_LS_valid,
   output logic            LS_MEM_ready,
   input  logic [XLEN-1:0] MEM_LS_PC,
   input  logic [XLEN-1:0] MEM_LS_next_PC,
   input  logic [31:0]     MEM_LS_inst,
   input  logic [5:0]      MEM_LS_ctrl,
   input  logic            MEM_LS_csr_ren,
   input  logic [11:0]     MEM_LS_csr_addr,
   input  logic [XLEN-1:0] MEM_LS_trap_cause,
   input  logic [XLEN-1:0] MEM_LS_trap_tval,
   input  logic [4:0]      MEM_LS_rd,
   input  logic            MEM_LS_dest_wen,
   input  logic            MEM_LS_load,
   input  logic [1:0]      MEM_LS_load_size,
   input  logic            MEM_LS_load_unsigned,
   input  logic [2:0]      MEM_LS_load_offset,
   input  logic [XLEN-1:0] MEM_LS_data,
   output logic            LS_WB_reg_ls_valid,
   output logic [XLEN-1:0] LS_WB_reg_PC,
   output logic [XLEN-1:0] LS_WB_reg_next_PC,
   output logic [31:0]     LS_WB_reg_inst,
   output logic            LS_WB_reg_sflush_valid,
   output logic            LS_WB_reg_trap_valid,
   output logic            LS_WB_reg_mret_valid,
   output logic            LS_WB_reg_sret_valid,
   output logic            LS_WB_reg_dret_valid,
   output logic [XLEN-1:0] LS_WB_reg_trap_cause,
   output logic [XLEN-1:0] LS_WB_reg_trap_tval,
   output logic            LS_WB_reg_csr_wen,
   output logic            LS_WB_reg_csr_ren,
   output logic [11:0]     LS_WB_reg_csr_addr,
   output logic [4:0]      LS_WB_reg_rd,
   output logic            LS_WB_reg_dest_wen,
   output logic [XLEN-1:0] LS_WB_reg_data
);

   logic [XLEN-1:0] aligned_data;
   ls_beat_t        in_beat;
   ls_beat_t        out_q, out_d;
   logic            out_valid_q, out_valid_d;

   load_align #(.XLEN(XLEN)) u_load_align (
      .raw_data_i (MEM_LS_data),
      .size_i     (ls_size_e'(MEM_LS_load_size)),
      .unsigned_i (MEM_LS_load_unsigned),
      .offset_i   (MEM_LS_load_offset),
      .data_o     (aligned_data)
   );

   always_comb begin
      in_beat              = '0;
      in_beat.pc           = MEM_LS_PC;
      in_beat.next_pc      = MEM_LS_next_PC;
      in_beat.inst         = MEM_LS_inst;
      in_beat.sflush_valid = MEM_LS_ctrl[CTRL_SFLUSH];
      in_beat.trap_valid   = MEM_LS_ctrl[CTRL_TRAP];
      in_beat.mret_valid   = MEM_LS_ctrl[CTRL_MRET];
      in_beat.sret_valid   = MEM_LS_ctrl[CTRL_SRET];
      in_beat.dret_valid   = MEM_LS_ctrl[CTRL_DRET];
      in_beat.csr_wen      = MEM_LS_ctrl[CTRL_CSR_WEN];
      in_beat.trap_cause   = MEM_LS_trap_cause;
      in_beat.trap_tval    = MEM_LS_trap_tval;
      in_beat.csr_ren      = MEM_LS_csr_ren;
      in_beat.csr_addr     = MEM_LS_csr_addr;
      in_beat.rd           = MEM_LS_rd;
      in_beat.dest_wen     = MEM_LS_dest_wen;
      in_beat.data         = MEM_LS_load ? aligned_data : MEM_LS_data;
   end

`ifdef LS_WB_SKID_BUF_EN
   ls_beat_t skid_q, skid_d;
   logic     skid_valid_q, skid_valid_d;
   logic     in_fire;

   assign LS_MEM_ready = !skid_valid_q;

   // Ready only depends on skid occupancy, so a beat can only be accepted
   // into an occupied output slot when the skid is free to catch it.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      in_fire      = MEM_LS_valid & LS_MEM_ready;
      if (WB_LS_flush_flag) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || WB_LS_ls_ready) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_d       = in_beat;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = in_beat;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   logic load_en;

   assign LS_MEM_ready = !out_valid_q | WB_LS_ls_ready;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      load_en     = MEM_LS_valid & LS_MEM_ready & !WB_LS_flush_flag;
      if (WB_LS_flush_flag) begin
         out_valid_d = 1'b0;
      end else if (load_en) begin
         out_d       = in_beat;
         out_valid_d = 1'b1;
      end else if (WB_LS_ls_ready) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign LS_WB_reg_ls_valid     = out_valid_q;
   assign LS_WB_reg_PC           = out_q.pc;
   assign LS_WB_reg_next_PC      = out_q.next_pc;
   assign LS_WB_reg_inst         = out_q.inst;
   assign LS_WB_reg_sflush_valid = out_q.sflush_valid;
   assign LS_WB_reg_trap_valid   = out_q.trap_valid;
   assign LS_WB_reg_mret_valid   = out_q.mret_valid;
   assign LS_WB_reg_sret_valid   = out_q.sret_valid;
   assign LS_WB_reg_dret_valid   = out_q.dret_valid;
   assign LS_WB_reg_trap_cause   = out_q.trap_cause;
   assign LS_WB_reg_trap_tval    = out_q.trap_tval;
   assign LS_WB_reg_csr_wen      = out_q.csr_wen;
   assign LS_WB_reg_csr_ren      = out_q.csr_ren;
   assign LS_WB_reg_csr_addr     = out_q.csr_addr;
   assign LS_WB_reg_rd           = out_q.rd;
   assign LS_WB_reg_dest_wen     = out_q.dest_wen;
   assign LS_WB_reg_data         = out_q.data;

endmodule

// File: tb/tb_ls_wb_stage.sv
// Directed self-checking bench for ls_wb_stage (either skid build).
module tb_ls_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        WB_LS_ls_ready, WB_LS_flush_flag, MEM_LS_valid, LS_MEM_ready;
   logic [63:0] MEM_LS_PC, MEM_LS_next_PC, MEM_LS_trap_cause, MEM_LS_trap_tval, MEM_LS_data;
   logic [31:0] MEM_LS_inst;
   logic [5:0]  MEM_LS_ctrl;
   logic        MEM_LS_csr_ren, MEM_LS_dest_wen, MEM_LS_load, MEM_LS_load_unsigned;
   logic [11:0] MEM_LS_csr_addr;
   logic [4:0]  MEM_LS_rd;
   logic [1:0]  MEM_LS_load_size;
   logic [2:0]  MEM_LS_load_offset;

   logic        LS_WB_reg_ls_valid;
   logic [63:0] LS_WB_reg_PC, LS_WB_reg_next_PC, LS_WB_reg_trap_cause, LS_WB_reg_trap_tval, LS_WB_reg_data;
   logic [31:0] LS_WB_reg_inst;
   logic        LS_WB_reg_sflush_valid, LS_WB_reg_trap_valid, LS_WB_reg_mret_valid;
   logic        LS_WB_reg_sret_valid, LS_WB_reg_dret_valid, LS_WB_reg_csr_wen, LS_WB_reg_csr_ren;
   logic [11:0] LS_WB_reg_csr_addr;
   logic [4:0]  LS_WB_reg_rd;
   logic        LS_WB_reg_dest_wen;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   ls_wb_stage #(.XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .WB_LS_ls_ready(WB_LS_ls_ready), .WB_LS_flush_flag(WB_LS_flush_flag),
      .MEM_LS_valid(MEM_LS_valid), .LS_MEM_ready(LS_MEM_ready),
      .MEM_LS_PC(MEM_LS_PC), .MEM_LS_next_PC(MEM_LS_next_PC), .MEM_LS_inst(MEM_LS_inst),
      .MEM_LS_ctrl(MEM_LS_ctrl), .MEM_LS_csr_ren(MEM_LS_csr_ren), .MEM_LS_csr_addr(MEM_LS_csr_addr),
      .MEM_LS_trap_cause(MEM_LS_trap_cause), .MEM_LS_trap_tval(MEM_LS_trap_tval),
      .MEM_LS_rd(MEM_LS_rd), .MEM_LS_dest_wen(MEM_LS_dest_wen), .MEM_LS_load(MEM_LS_load),
      .MEM_LS_load_size(MEM_LS_load_size), .MEM_LS_load_unsigned(MEM_LS_load_unsigned),
      .MEM_LS_load_offset(MEM_LS_load_offset), .MEM_LS_data(MEM_LS_data),
      .LS_WB_reg_ls_valid(LS_WB_reg_ls_valid), .LS_WB_reg_PC(LS_WB_reg_PC),
      .LS_WB_reg_next_PC(LS_WB_reg_next_PC), .LS_WB_reg_inst(LS_WB_reg_inst),
      .LS_WB_reg_sflush_valid(LS_WB_reg_sflush_valid), .LS_WB_reg_trap_valid(LS_WB_reg_trap_valid),
      .LS_WB_reg_mret_valid(LS_WB_reg_mret_valid), .LS_WB_reg_sret_valid(LS_WB_reg_sret_valid),
      .LS_WB_reg_dret_valid(LS_WB_reg_dret_valid), .LS_WB_reg_trap_cause(LS_WB_reg_trap_cause),
      .LS_WB_reg_trap_tval(LS_WB_reg_trap_tval), .LS_WB_reg_csr_wen(LS_WB_reg_csr_wen),
      .LS_WB_reg_csr_ren(LS_WB_reg_csr_ren), .LS_WB_reg_csr_addr(LS_WB_reg_csr_addr),
      .LS_WB_reg_rd(LS_WB_reg_rd), .LS_WB_reg_dest_wen(LS_WB_reg_dest_wen),
      .LS_WB_reg_data(LS_WB_reg_data)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      WB_LS_flush_flag     = 1'b0;
      MEM_LS_valid         = 1'b0;
      MEM_LS_PC            = '0;
      MEM_LS_next_PC       = '0;
      MEM_LS_inst          = '0;
      MEM_LS_ctrl          = '0;
      MEM_LS_csr_ren       = 1'b0;
      MEM_LS_csr_addr      = '0;
      MEM_LS_trap_cause    = '0;
      MEM_LS_trap_tval     = '0;
      MEM_LS_rd            = '0;
      MEM_LS_dest_wen      = 1'b0;
      MEM_LS_load          = 1'b0;
      MEM_LS_load_size     = '0;
      MEM_LS_load_unsigned = 1'b0;
      MEM_LS_load_offset   = '0;
      MEM_LS_data          = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one load beat, clock it in, and check the aligned result.
   task automatic load_case(input string tag, input logic [1:0] size, input logic uns,
                            input logic [2:0] off, input logic [63:0] data, input logic [63:0] exp);
      MEM_LS_valid = 1'b1; MEM_LS_load = 1'b1;
      MEM_LS_load_size = size; MEM_LS_load_unsigned = uns;
      MEM_LS_load_offset = off; MEM_LS_data = data;
      step();
      check_eq({tag, "_valid"}, {63'd0, LS_WB_reg_ls_valid}, 64'd1);
      check_eq(tag, LS_WB_reg_data, exp);
   endtask

   int unsigned sent, recv;
   logic        hs_in, hs_out;

   initial begin
      clear_inputs();
      WB_LS_ls_ready = 1'b1;
      rst_n = 1'b0;
      #3;
      check_eq("rst_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
      check_eq("rst_data", LS_WB_reg_data, 64'd0);
      check_eq("rst_cause", LS_WB_reg_trap_cause, 64'd0);
      check_eq("rst_ready", {63'd0, LS_MEM_ready}, 64'd1);
      #10 rst_n = 1'b1;
      step();

      // Load alignment
      MEM_LS_PC = 64'h1000; MEM_LS_rd = 5'd5; MEM_LS_dest_wen = 1'b1;
      load_case("lb_signed", 2'd0, 1'b0, 3'd1, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FF80);
      check_eq("lb_pc", LS_WB_reg_PC, 64'h1000);
      check_eq("lb_rd", {59'd0, LS_WB_reg_rd}, 64'd5);
      load_case("lbu", 2'd0, 1'b1, 3'd1, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0080);
      load_case("lw_off4", 2'd2, 1'b0, 3'd4, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
      load_case("lh_off6", 2'd1, 1'b0, 3'd6, 64'h7FFF_0000_0000_0000, 64'h0000_0000_0000_7FFF);
      load_case("lhu_off2", 2'd1, 1'b1, 3'd2, 64'h0000_0000_9ABC_0000, 64'h0000_0000_0000_9ABC);
      load_case("ld_uns", 2'd3, 1'b1, 3'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
      MEM_LS_load = 1'b0; MEM_LS_data = 64'hDEAD_BEEF_0000_00F1; MEM_LS_load_offset = 3'd3;
      step();
      check_eq("nonload_data", LS_WB_reg_data, 64'hDEAD_BEEF_0000_00F1);
      MEM_LS_valid = 1'b0;
      step();
      check_eq("drain_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

      // Stall for 3 cycles with upstream always offering; no beat lost or duplicated
      clear_inputs();
      sent = 0; recv = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         MEM_LS_valid   = (sent < 4);
         MEM_LS_data    = 64'd100 + 64'(sent);
         WB_LS_ls_ready = (cyc >= 3);
         #1;
         hs_in  = MEM_LS_valid & LS_MEM_ready;
         hs_out = LS_WB_reg_ls_valid & WB_LS_ls_ready;
         if (cyc >= 1 && cyc <= 3) check_eq("stall_stable", LS_WB_reg_data, 64'd100);
`ifdef LS_WB_SKID_BUF_EN
         if (cyc == 2) check_eq("skid_ready_low", {63'd0, LS_MEM_ready}, 64'd0);
`else
         if (cyc == 1) check_eq("stall_ready_low", {63'd0, LS_MEM_ready}, 64'd0);
`endif
         if (hs_out) begin
            check_eq("stall_order", LS_WB_reg_data, 64'd100 + 64'(recv));
            recv++;
         end
         @(posedge clk);
         #1;
         if (hs_in) sent++;
      end
      check_eq("beats_in", 64'(sent), 64'd4);
      check_eq("beats_out", 64'(recv), 64'd4);
      clear_inputs();
      WB_LS_ls_ready = 1'b1;
      step();

      // Flush with simultaneous handshake kills the beat; next beat passes
      MEM_LS_valid = 1'b1; MEM_LS_data = 64'hAA; WB_LS_flush_flag = 1'b1;
      step();
      check_eq("flush_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
      WB_LS_flush_flag = 1'b0; MEM_LS_data = 64'hBB;
      step();
      check_eq("post_flush_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
      check_eq("post_flush_data", LS_WB_reg_data, 64'hBB);

      // Trap beat fields reproduced exactly
      MEM_LS_ctrl = 6'b010000; MEM_LS_trap_cause = 64'd13; MEM_LS_trap_tval = 64'h8000_1003;
      MEM_LS_data = 64'h0123_4567_89AB_CDEF; MEM_LS_PC = 64'h8000_1000; MEM_LS_next_PC = 64'h8000_1004;
      MEM_LS_inst = 32'h0000_2003; MEM_LS_csr_ren = 1'b1; MEM_LS_csr_addr = 12'h341;
      step();
      check_eq("trap_valid", {63'd0, LS_WB_reg_trap_valid}, 64'd1);
      check_eq("trap_sflush", {63'd0, LS_WB_reg_sflush_valid}, 64'd0);
      check_eq("trap_cause", LS_WB_reg_trap_cause, 64'd13);
      check_eq("trap_tval", LS_WB_reg_trap_tval, 64'h8000_1003);
      check_eq("trap_data", LS_WB_reg_data, 64'h0123_4567_89AB_CDEF);
      check_eq("trap_next_pc", LS_WB_reg_next_PC, 64'h8000_1004);
      check_eq("trap_inst", {32'd0, LS_WB_reg_inst}, 64'h0000_2003);
      check_eq("trap_csr", {51'd0, LS_WB_reg_csr_ren, LS_WB_reg_csr_addr}, {51'd0, 1'b1, 12'h341});
      MEM_LS_ctrl = 6'b101011;
      step();
      check_eq("ctrl_bits", {58'd0, LS_WB_reg_sflush_valid, LS_WB_reg_trap_valid, LS_WB_reg_mret_valid,
                             LS_WB_reg_sret_valid, LS_WB_reg_dret_valid, LS_WB_reg_csr_wen}, 64'b101011);

      // Asynchronous reset in the middle of a stall
      clear_inputs();
      WB_LS_ls_ready = 1'b0;
      MEM_LS_valid = 1'b1; MEM_LS_data = 64'h55; MEM_LS_PC = 64'h2000;
      step();
      MEM_LS_valid = 1'b0;
      check_eq("prereset_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
      check_eq("async_rst_data", LS_WB_reg_data, 64'd0);
      check_eq("async_rst_pc", LS_WB_reg_PC, 64'd0);
      step();
      #3 rst_n = 1'b1;
      step();
      check_eq("post_rst_ready", {63'd0, LS_MEM_ready}, 64'd1);
      check_eq("post_rst_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
